// File: rtl/btn_input_ctrl.sv
// Debounced button front end: per-button synchronizer and debounce counter,
// press/release event flags, and a first-word-fall-through event queue.
module btn_input_ctrl #(
  parameter int BUTTONS         = 3,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BUTTONS-1:0] btn,
  output logic [BUTTONS-1:0] btn_state,
  output logic               evt_valid,
  output logic [3:0]         evt_code,
  input  logic               evt_ready,
  output logic               evt_overflow,
  input  logic               ovf_clr
);

  localparam int CW   = $clog2(DEBOUNCE_CYCLES);
  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW = AW + 1;
  localparam logic [BUTTONS-1:0] IDLE_PAD = {BUTTONS{ACTIVE_LOW}};
  localparam logic [CW-1:0]      CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNTW-1:0]    FULL_CNT = CNTW'(FIFO_DEPTH);

  logic [BUTTONS-1:0] sync1_q, sync2_q, level;
  logic [BUTTONS-1:0] state_q, state_d;
  logic [CW-1:0]      cnt_q [BUTTONS];
  logic [CW-1:0]      cnt_d [BUTTONS];
  logic [BUTTONS-1:0] press_pend_q, press_pend_d, rel_pend_q, rel_pend_d;
  logic [BUTTONS-1:0] press_clr, rel_clr;
  logic               arb_req;
  logic [3:0]         arb_code;
  logic [3:0]         mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]    count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               full, push, pop;

  // Sync flops hold raw pad levels; inversion afterwards gives pressed=1.
  assign level = sync2_q ^ {BUTTONS{ACTIVE_LOW}};

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    state_d = state_q;
    for (int i = 0; i < BUTTONS; i++) begin
      cnt_d[i] = '0;
      if (level[i] != state_q[i]) begin
        if (cnt_q[i] == CNT_MAX) state_d[i] = level[i];
        else                     cnt_d[i]   = cnt_q[i] + CW'(1);
      end
    end
  end

  // Lowest index wins; press outranks release on the same button.
  always_comb begin
    arb_req   = 1'b0;
    arb_code  = 4'h0;
    press_clr = '0;
    rel_clr   = '0;
    for (int i = 0; i < BUTTONS; i++) begin
      if (!arb_req) begin
        if (press_pend_q[i]) begin
          arb_req      = 1'b1;
          arb_code     = {1'b0, 3'(i)};
          press_clr[i] = 1'b1;
        end else if (rel_pend_q[i]) begin
          arb_req    = 1'b1;
          arb_code   = {1'b1, 3'(i)};
          rel_clr[i] = 1'b1;
        end
      end
    end
  end

  // A new edge on a flag being cleared this cycle keeps it set.
  assign press_pend_d = (press_pend_q & ~press_clr) | (state_d & ~state_q);
  assign rel_pend_d   = (rel_pend_q & ~rel_clr)     | (~state_d & state_q);

  assign full      = (count_q == FULL_CNT);
  assign evt_valid = (count_q != '0);
  assign pop       = evt_valid && evt_ready;
  assign push      = arb_req && (!full || pop);

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
    if (arb_req && !push) ovf_d = 1'b1;
    else if (ovf_clr)     ovf_d = 1'b0;
    else                  ovf_d = ovf_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      sync1_q      <= IDLE_PAD;
      sync2_q      <= IDLE_PAD;
      state_q      <= '0;
      for (int i = 0; i < BUTTONS; i++) cnt_q[i] <= '0;
      press_pend_q <= '0;
      rel_pend_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
    end else begin
      sync1_q      <= btn;
      sync2_q      <= sync1_q;
      state_q      <= state_d;
      for (int i = 0; i < BUTTONS; i++) cnt_q[i] <= cnt_d[i];
      press_pend_q <= press_pend_d;
      rel_pend_q   <= rel_pend_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
    end
  end

  // NOTE: queue storage is not reset; stale entries are unreachable once count is 0.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= arb_code;
  end

  assign btn_state    = state_q;
  assign evt_code     = evt_valid ? mem_q[rd_ptr_q] : 4'h0;
  assign evt_overflow = ovf_q;

endmodule

// File: tb/tb_btn_input_ctrl.sv
// Directed bench for btn_input_ctrl with a short debounce window.
module tb_btn_input_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] btn;
  logic [2:0] btn_state;
  logic       evt_valid;
  logic [3:0] evt_code;
  logic       evt_ready;
  logic       evt_overflow;
  logic       ovf_clr;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  btn_input_ctrl #(
    .BUTTONS(3), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn), .btn_state(btn_state),
    .evt_valid(evt_valid), .evt_code(evt_code), .evt_ready(evt_ready),
    .evt_overflow(evt_overflow), .ovf_clr(ovf_clr)
  );

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; btn = 3'b111; evt_ready = 1'b0; ovf_clr = 1'b0;
    cycles(3);
    vec_cnt++; if (btn_state !== 3'b000) begin err_cnt++; $display("FAIL rst_state: got %b want 000", btn_state); end
    vec_cnt++; if (evt_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_valid: got %b want 0", evt_valid); end
    vec_cnt++; if (evt_code !== 4'h0) begin err_cnt++; $display("FAIL rst_code: got %h want 0", evt_code); end
    vec_cnt++; if (evt_overflow !== 1'b0) begin err_cnt++; $display("FAIL rst_ovf: got %b want 0", evt_overflow); end
    rst = 1'b0;
    cycles(3);
    vec_cnt++; if (evt_valid !== 1'b0 || btn_state !== 3'b000) begin err_cnt++; $display("FAIL post_rst_idle: valid=%b state=%b want 0/000", evt_valid, btn_state); end
  endtask

  task automatic test_press_latency;
    btn[0] = 1'b0;
    cycles(5);
    vec_cnt++; if (btn_state !== 3'b000) begin err_cnt++; $display("FAIL lat_early: got %b want 000", btn_state); end
    cycles(1);
    vec_cnt++; if (btn_state !== 3'b001) begin err_cnt++; $display("FAIL lat_exact: got %b want 001", btn_state); end
    vec_cnt++; if (evt_valid !== 1'b0) begin err_cnt++; $display("FAIL lat_no_evt_yet: got %b want 0", evt_valid); end
    cycles(1);
    vec_cnt++; if (evt_valid !== 1'b1 || evt_code !== 4'h0) begin err_cnt++; $display("FAIL press_evt: valid=%b code=%h want 1/0", evt_valid, evt_code); end
    evt_ready = 1'b1; cycles(1); evt_ready = 1'b0;
    vec_cnt++; if (evt_valid !== 1'b0) begin err_cnt++; $display("FAIL press_pop: valid=%b want 0", evt_valid); end
    btn[0] = 1'b1;
    cycles(6);
    vec_cnt++; if (btn_state !== 3'b000) begin err_cnt++; $display("FAIL release_lat: got %b want 000", btn_state); end
    cycles(1);
    vec_cnt++; if (evt_valid !== 1'b1 || evt_code !== 4'h8) begin err_cnt++; $display("FAIL release_evt: valid=%b code=%h want 1/8", evt_valid, evt_code); end
    evt_ready = 1'b1; cycles(1); evt_ready = 1'b0;
    vec_cnt++; if (evt_valid !== 1'b0) begin err_cnt++; $display("FAIL release_pop: valid=%b want 0", evt_valid); end
  endtask

  task automatic test_bounce;
    for (int k = 0; k < 5; k++) begin
      btn[1] = 1'b0; cycles(2);
      btn[1] = 1'b1; cycles(2);
      vec_cnt++; if (btn_state !== 3'b000) begin err_cnt++; $display("FAIL bounce_state[%0d]: got %b want 000", k, btn_state); end
    end
    cycles(8);
    vec_cnt++; if (btn_state !== 3'b000 || evt_valid !== 1'b0) begin err_cnt++; $display("FAIL bounce_final: state=%b valid=%b want 000/0", btn_state, evt_valid); end
  endtask

  task automatic test_simultaneous;
    logic [3:0] exp_codes [6] = '{4'h0, 4'h1, 4'h2, 4'h8, 4'h9, 4'hA};
    logic [2:0] pads      [2] = '{3'b000, 3'b111};
    logic [2:0] states    [2] = '{3'b111, 3'b000};
    evt_ready = 1'b1;
    for (int p = 0; p < 2; p++) begin
      btn = pads[p];
      cycles(6);
      vec_cnt++; if (btn_state !== states[p]) begin err_cnt++; $display("FAIL simul_state[%0d]: got %b want %b", p, btn_state, states[p]); end
      for (int i = 0; i < 3; i++) begin
        cycles(1);
        vec_cnt++; if (evt_valid !== 1'b1 || evt_code !== exp_codes[p*3+i]) begin err_cnt++; $display("FAIL simul_evt[%0d]: valid=%b code=%h want 1/%h", p*3+i, evt_valid, evt_code, exp_codes[p*3+i]); end
      end
      cycles(1);
      vec_cnt++; if (evt_valid !== 1'b0) begin err_cnt++; $display("FAIL simul_empty[%0d]: valid=%b want 0", p, evt_valid); end
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_overflow;
    logic [3:0] exp_codes [4] = '{4'h0, 4'h1, 4'h2, 4'h8};
    btn = 3'b000;
    cycles(10);
    vec_cnt++; if (evt_valid !== 1'b1 || evt_code !== 4'h0) begin err_cnt++; $display("FAIL ovf_head: valid=%b code=%h want 1/0", evt_valid, evt_code); end
    btn = 3'b011;
    cycles(6);
    vec_cnt++; if (btn_state !== 3'b100 || evt_overflow !== 1'b0) begin err_cnt++; $display("FAIL ovf_pre: state=%b ovf=%b want 100/0", btn_state, evt_overflow); end
    cycles(1);
    vec_cnt++; if (evt_overflow !== 1'b0) begin err_cnt++; $display("FAIL ovf_fourth: got %b want 0", evt_overflow); end
    cycles(1);
    vec_cnt++; if (evt_overflow !== 1'b1) begin err_cnt++; $display("FAIL ovf_fifth: got %b want 1", evt_overflow); end
    cycles(2);
    vec_cnt++; if (evt_overflow !== 1'b1) begin err_cnt++; $display("FAIL ovf_sticky: got %b want 1", evt_overflow); end
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vec_cnt++; if (evt_valid !== 1'b1 || evt_code !== exp_codes[i]) begin err_cnt++; $display("FAIL ovf_drain[%0d]: valid=%b code=%h want 1/%h", i, evt_valid, evt_code, exp_codes[i]); end
      cycles(1);
    end
    vec_cnt++; if (evt_valid !== 1'b0) begin err_cnt++; $display("FAIL ovf_dropped: valid=%b code=%h want empty", evt_valid, evt_code); end
    evt_ready = 1'b0;
    ovf_clr = 1'b1; cycles(1); ovf_clr = 1'b0;
    vec_cnt++; if (evt_overflow !== 1'b0) begin err_cnt++; $display("FAIL ovf_clr: got %b want 0", evt_overflow); end
  endtask

  task automatic test_full_pop;
    logic [3:0] exp_codes [4] = '{4'h1, 4'hA, 4'h8, 4'h9};
    btn = 3'b100;
    cycles(10);
    vec_cnt++; if (btn_state !== 3'b011 || evt_code !== 4'h0) begin err_cnt++; $display("FAIL full_setup: state=%b code=%h want 011/0", btn_state, evt_code); end
    btn = 3'b111;
    cycles(7);
    vec_cnt++; if (evt_valid !== 1'b1 || evt_code !== 4'h0 || evt_overflow !== 1'b0) begin err_cnt++; $display("FAIL full_head: valid=%b code=%h ovf=%b want 1/0/0", evt_valid, evt_code, evt_overflow); end
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycles(1);
      vec_cnt++; if (evt_valid !== 1'b1 || evt_code !== exp_codes[i]) begin err_cnt++; $display("FAIL full_order[%0d]: valid=%b code=%h want 1/%h", i, evt_valid, evt_code, exp_codes[i]); end
    end
    cycles(1);
    vec_cnt++; if (evt_valid !== 1'b0 || evt_overflow !== 1'b0) begin err_cnt++; $display("FAIL full_end: valid=%b ovf=%b want 0/0", evt_valid, evt_overflow); end
    evt_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    btn = 3'b000;
    cycles(10);
    vec_cnt++; if (evt_valid !== 1'b1 || evt_code !== 4'h0) begin err_cnt++; $display("FAIL mid_queued: valid=%b code=%h want 1/0", evt_valid, evt_code); end
    btn = 3'b010;
    cycles(3);
    vec_cnt++; if (btn_state !== 3'b111) begin err_cnt++; $display("FAIL mid_debounce: got %b want 111", btn_state); end
    rst = 1'b1; cycles(1); rst = 1'b0;
    vec_cnt++; if (evt_valid !== 1'b0 || evt_code !== 4'h0 || btn_state !== 3'b000 || evt_overflow !== 1'b0) begin err_cnt++; $display("FAIL mid_rst: valid=%b code=%h state=%b ovf=%b want 0/0/000/0", evt_valid, evt_code, btn_state, evt_overflow); end
    cycles(5);
    vec_cnt++; if (btn_state !== 3'b000 || evt_valid !== 1'b0) begin err_cnt++; $display("FAIL held_early: state=%b valid=%b want 000/0", btn_state, evt_valid); end
    cycles(1);
    vec_cnt++; if (btn_state !== 3'b101) begin err_cnt++; $display("FAIL held_state: got %b want 101", btn_state); end
    cycles(1);
    vec_cnt++; if (evt_valid !== 1'b1 || evt_code !== 4'h0) begin err_cnt++; $display("FAIL held_evt0: valid=%b code=%h want 1/0", evt_valid, evt_code); end
    evt_ready = 1'b1;
    cycles(1);
    vec_cnt++; if (evt_valid !== 1'b1 || evt_code !== 4'h2) begin err_cnt++; $display("FAIL held_evt2: valid=%b code=%h want 1/2", evt_valid, evt_code); end
    cycles(1);
    vec_cnt++; if (evt_valid !== 1'b0) begin err_cnt++; $display("FAIL held_empty: valid=%b code=%h want empty", evt_valid, evt_code); end
    cycles(8);
    vec_cnt++; if (evt_valid !== 1'b0) begin err_cnt++; $display("FAIL no_stale: valid=%b code=%h want empty", evt_valid, evt_code); end
    evt_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_press_latency();
    test_bounce();
    test_simultaneous();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
